// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared types and constants for the ALU command front end.
// The optional result watchdog is controlled by the ALU_TIMEOUT_EN macro.
package alu_cmd_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_A    = 3'd1,
        GET_B    = 3'd2,
        GET_FUN  = 3'd3,
        ALU_RUN  = 3'd4,
        WAIT_RES = 3'd5,
        SEND_LO  = 3'd6,
        SEND_HI  = 3'd7
    } ctrl_state_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_WAIT = 2'd1,
        TX_SEND = 2'd2
    } tx_state_t;

    localparam logic [7:0]  CMD_ALU_OPER_DEF   = 8'hCC;
    localparam logic [7:0]  CMD_ALU_NOOP_DEF   = 8'hDD;
    localparam int          TIMEOUT_CYCLES_DEF = 15;
    localparam logic [15:0] TIMEOUT_PATTERN    = 16'hEEEE;
    localparam int          FUN_WIDTH          = 4;

endpackage

// File: rtl/alu_cmd_ctrl_tx_byte_sender.sv
// Single-byte valid/busy handshake towards the UART transmitter.
// Handshake: wait for tx_busy=0, raise tx_vld with tx_data, hold both until tx_busy=1 is sampled.
module alu_cmd_ctrl_tx_byte_sender
    import alu_cmd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_vld,
    output logic                  done,
    output logic                  idle,
    output logic [1:0]            dbg_state
);

    tx_state_t             state;
    tx_state_t             state_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  vld_q;
    logic                  vld_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= TX_IDLE;
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            data_q <= data_nxt;
            vld_q  <= vld_nxt;
        end
    end

    // start is only honoured in TX_IDLE; the byte is latched so the caller may change its mux.
    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        vld_nxt   = vld_q;
        done      = 1'b0;
        case (state)
            TX_IDLE: begin
                if (start) begin
                    data_nxt = data;
                    if (!tx_busy) begin
                        vld_nxt   = 1'b1;
                        state_nxt = TX_SEND;
                    end else begin
                        state_nxt = TX_WAIT;
                    end
                end
            end
            TX_WAIT: begin
                if (!tx_busy) begin
                    vld_nxt   = 1'b1;
                    state_nxt = TX_SEND;
                end
            end
            TX_SEND: begin
                if (tx_busy) begin
                    vld_nxt   = 1'b0;
                    done      = 1'b1;
                    state_nxt = TX_IDLE;
                end
            end
            default: begin
                vld_nxt   = 1'b0;
                state_nxt = TX_IDLE;
            end
        endcase
    end

    assign tx_data   = data_q;
    assign tx_vld    = vld_q;
    assign idle      = (state == TX_IDLE);
    assign dbg_state = state;

endmodule

// File: rtl/alu_cmd_ctrl.sv
// ALU command front end: parses RX command frames, drives the ALU, returns the result low byte first.
// Define ALU_TIMEOUT_EN to add the OUT_VALID watchdog that answers 0xEE 0xEE on a missing result.
module alu_cmd_ctrl
    import alu_cmd_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    RES_WIDTH      = 16,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_OPER   = DATA_WIDTH'(CMD_ALU_OPER_DEF),
    parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOOP   = DATA_WIDTH'(CMD_ALU_NOOP_DEF),
    parameter int                    TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    input  logic [RES_WIDTH-1:0]  ALU_OUT,
    input  logic                  OUT_VALID,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_BUSY,
    output logic                  CTRL_BUSY,
    output logic [2:0]            dbg_state,
    output logic [1:0]            dbg_tx_state
);

    if (RES_WIDTH != 2 * DATA_WIDTH) begin : g_res_width_check
        $error("alu_cmd_ctrl: RES_WIDTH must equal 2*DATA_WIDTH");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 16) begin : g_timeout_check
        $error("alu_cmd_ctrl: TIMEOUT_CYCLES must fit the 4-bit watchdog");
    end

    ctrl_state_t           state;
    ctrl_state_t           state_nxt;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [FUN_WIDTH-1:0]  fun_q;
    logic [DATA_WIDTH-1:0] res_hi_q;
    logic                  cap_a;
    logic                  cap_b;
    logic                  cap_fun;
    logic                  cap_res;
    logic                  res_timeout;
    logic [RES_WIDTH-1:0]  res_nxt;
    logic                  tx_start;
    logic [DATA_WIDTH-1:0] tx_byte;
    logic                  tx_done;
    logic                  tx_idle;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            fun_q    <= '0;
            res_hi_q <= '0;
        end else begin
            state <= state_nxt;
            if (cap_a) begin
                a_q <= RX_P_DATA;
            end
            if (cap_b) begin
                b_q <= RX_P_DATA;
            end
            if (cap_fun) begin
                fun_q <= RX_P_DATA[FUN_WIDTH-1:0];
            end
            if (cap_res) begin
                res_hi_q <= res_nxt[RES_WIDTH-1:DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cap_a     = 1'b0;
        cap_b     = 1'b0;
        cap_fun   = 1'b0;
        cap_res   = 1'b0;
        case (state)
            IDLE: begin
                if (RX_D_VLD && RX_P_DATA == CMD_ALU_OPER) begin
                    state_nxt = GET_A;
                end else if (RX_D_VLD && RX_P_DATA == CMD_ALU_NOOP) begin
                    state_nxt = GET_FUN;
                end
            end
            GET_A: begin
                if (RX_D_VLD) begin
                    cap_a     = 1'b1;
                    state_nxt = GET_B;
                end
            end
            GET_B: begin
                if (RX_D_VLD) begin
                    cap_b     = 1'b1;
                    state_nxt = GET_FUN;
                end
            end
            GET_FUN: begin
                if (RX_D_VLD) begin
                    cap_fun   = 1'b1;
                    state_nxt = ALU_RUN;
                end
            end
            ALU_RUN: begin
                state_nxt = WAIT_RES;
            end
            WAIT_RES: begin
                if (OUT_VALID || res_timeout) begin
                    cap_res   = 1'b1;
                    state_nxt = SEND_LO;
                end
            end
            SEND_LO: begin
                if (tx_done) begin
                    state_nxt = SEND_HI;
                end
            end
            SEND_HI: begin
                if (tx_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef ALU_TIMEOUT_EN
    logic [3:0] wait_cnt;

    // Held at zero outside WAIT_RES, so every entry starts a fresh count.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wait_cnt <= '0;
        end else if (state != WAIT_RES) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign res_timeout = (state == WAIT_RES) && !OUT_VALID
                         && (wait_cnt == 4'(TIMEOUT_CYCLES - 1));
`else
    assign res_timeout = 1'b0;
`endif

    assign res_nxt = res_timeout ? RES_WIDTH'(TIMEOUT_PATTERN) : ALU_OUT;

    // The low byte is handed to the sender straight from the capture cycle to save a cycle
    // of latency; only the high byte has to wait in res_hi_q.
    assign tx_start = cap_res || (state == SEND_HI && tx_idle);
    assign tx_byte  = (state == WAIT_RES) ? res_nxt[DATA_WIDTH-1:0] : res_hi_q;

    alu_cmd_ctrl_tx_byte_sender #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx_byte_sender (
        .clk       (CLK),
        .rst_n     (RST),
        .start     (tx_start),
        .data      (tx_byte),
        .tx_busy   (TX_BUSY),
        .tx_data   (TX_P_DATA),
        .tx_vld    (TX_D_VLD),
        .done      (tx_done),
        .idle      (tx_idle),
        .dbg_state (dbg_tx_state)
    );

    assign ALU_A     = a_q;
    assign ALU_B     = b_q;
    assign ALU_FUN   = fun_q;
    assign ALU_EN    = (state == ALU_RUN);
    assign CTRL_BUSY = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Randomised bench for alu_cmd_ctrl: frame-level command model, ALU responder and UART TX model.
// Build with +define+ALU_TIMEOUT_EN to also exercise the missing-result watchdog.
module tb_alu_cmd_ctrl;
    import alu_cmd_ctrl_pkg::*;

    localparam logic [7:0] CMD_OPER = 8'hCC;
    localparam logic [7:0] CMD_NOOP = 8'hDD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_p_data = 8'h00;
    logic        rx_d_vld = 1'b0;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_fun;
    logic        alu_en;
    logic [15:0] alu_out = 16'h0000;
    logic        out_valid;
    logic        ov_resp = 1'b0;
    logic        ov_stray = 1'b0;
    logic [7:0]  tx_p_data;
    logic        tx_d_vld;
    logic        tx_busy;
    logic        ack_busy = 1'b0;
    logic        force_busy = 1'b0;
    logic        ctrl_busy;
    logic [2:0]  dbg_state;
    logic [1:0]  dbg_tx_state;

    assign out_valid = ov_resp | ov_stray;
    assign tx_busy   = ack_busy | force_busy;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int fun_cyc = 0;
    int lat_exp = 0;
    bit lat_pending = 1'b0;
    bit alu_silent = 1'b0;
    bit rand_dly = 1'b0;

    logic [7:0]  mdl_a = 8'h00;
    logic [7:0]  mdl_b = 8'h00;
    logic [7:0]  exp_q[$];
    logic [19:0] alu_exp_q[$];

    alu_cmd_ctrl dut (
        .CLK          (clk),
        .RST          (rst_n),
        .RX_P_DATA    (rx_p_data),
        .RX_D_VLD     (rx_d_vld),
        .ALU_A        (alu_a),
        .ALU_B        (alu_b),
        .ALU_FUN      (alu_fun),
        .ALU_EN       (alu_en),
        .ALU_OUT      (alu_out),
        .OUT_VALID    (out_valid),
        .TX_P_DATA    (tx_p_data),
        .TX_D_VLD     (tx_d_vld),
        .TX_BUSY      (tx_busy),
        .CTRL_BUSY    (ctrl_busy),
        .dbg_state    (dbg_state),
        .dbg_tx_state (dbg_tx_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", n_pass, n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Stand-in for the external ALU: any deterministic function of A, B, FUN will do.
    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return {8'h00, a & b};
            4'd4:    return {8'h00, a | b};
            default: return {b ^ {4'h0, f}, a};
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_d_vld  = 1'b1;
        rx_p_data = b;
        fun_cyc   = cyc;
        @(posedge clk);
        #1;
        rx_d_vld  = 1'b0;
        rx_p_data = 8'($urandom);
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic send_oper(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                             input bit lat);
        mdl_a = a;
        mdl_b = b;
        alu_exp_q.push_back({a, b, f});
        lat_pending = lat;
        send_byte(CMD_OPER);
        send_byte(a);
        send_byte(b);
        send_byte({4'($urandom_range(0, 15)), f});
    endtask

    task automatic send_noop(input logic [3:0] f, input bit lat);
        alu_exp_q.push_back({mdl_a, mdl_b, f});
        lat_pending = lat;
        send_byte(CMD_NOOP);
        send_byte({4'($urandom_range(0, 15)), f});
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n = 0;
        while (n < max_cyc && !(exp_q.size() == 0 && alu_exp_q.size() == 0
                                && !ctrl_busy && !tx_busy)) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_in_time"}, 32'(n < max_cyc), 1);
    endtask

    task automatic wait_state(input logic [2:0] st, input int max_cyc, input string tag);
        int n = 0;
        while (n < max_cyc && dbg_state !== st) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_state_reached"}, 32'(n < max_cyc), 1);
    endtask

    // Asynchronous reset: asserted mid-cycle and checked before any clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_fun"}, alu_fun, 0);
        check({tag, "_alu_en"}, alu_en, 0);
        check({tag, "_tx_data"}, tx_p_data, 0);
        check({tag, "_tx_vld"}, tx_d_vld, 0);
        check({tag, "_ctrl_busy"}, ctrl_busy, 0);
        check({tag, "_state"}, dbg_state, IDLE);
        check({tag, "_tx_state"}, dbg_tx_state, TX_IDLE);
        mdl_a = 8'h00;
        mdl_b = 8'h00;
        exp_q.delete();
        alu_exp_q.delete();
        lat_pending = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- ALU responder ----------------
    initial begin
        logic [19:0] op;
        logic [15:0] res;
        int          dly;
        forever begin
            @(negedge clk);
            if (rst_n && alu_en) begin
                if (alu_exp_q.size() == 0) begin
                    check("alu_en_unexpected", 1, 0);
                end else begin
                    op = alu_exp_q.pop_front();
                    check("alu_a", alu_a, op[19:12]);
                    check("alu_b", alu_b, op[11:4]);
                    check("alu_fun", alu_fun, op[3:0]);
                    check("alu_en_latency", cyc, fun_cyc + 1);
                    res = alu_model(op[19:12], op[11:4], op[3:0]);
                    dly = rand_dly ? $urandom_range(0, 2) : 0;
                    @(posedge clk);
                    repeat (dly) @(posedge clk);
                    #1;
                    if (alu_silent) begin
                        exp_q.push_back(8'hEE);
                        exp_q.push_back(8'hEE);
                        lat_exp = fun_cyc + 17;
                    end else begin
                        ov_resp = 1'b1;
                        alu_out = res;
                        exp_q.push_back(res[7:0]);
                        exp_q.push_back(res[15:8]);
                        lat_exp = fun_cyc + 3 + dly;
                    end
                    @(negedge clk);
                    check("alu_en_width", alu_en, 0);
                    @(posedge clk);
                    #1;
                    ov_resp = 1'b0;
                    alu_out = 16'($urandom);
                end
            end
        end
    end

    // ---------------- UART TX model / scoreboard ----------------
    initial begin
        logic [7:0] byte_v;
        int         hold;
        forever begin
            @(negedge clk);
            if (rst_n && tx_d_vld && !tx_busy) begin
                byte_v = tx_p_data;
                if (lat_pending) begin
                    lat_pending = 1'b0;
                    check("lo_byte_latency", cyc, lat_exp);
                end
                hold = $urandom_range(0, 3);
                for (int i = 0; i < hold; i++) begin
                    @(negedge clk);
                    check("tx_vld_held", tx_d_vld, 1);
                    check("tx_data_held", tx_p_data, byte_v);
                end
                if (exp_q.size() == 0) begin
                    check("tx_extra_byte", {24'h0, byte_v}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_byte", byte_v, exp_q.pop_front());
                end
                @(posedge clk);
                #1;
                ack_busy = 1'b1;
                @(posedge clk);
                #1;
                check("tx_vld_drop", tx_d_vld, 0);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                ack_busy = 1'b0;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int r;
        #3;
        check("por_alu_en", alu_en, 0);
        check("por_tx_vld", tx_d_vld, 0);
        check("por_state", dbg_state, IDLE);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // NOOP straight after reset uses zero operands
        send_noop(4'd4, 1'b1);
        wait_done(60, "noop_after_reset");

        // reset in the middle of GET_B aborts the frame
        send_byte(CMD_OPER);
        send_byte(8'h05);
        @(negedge clk);
        check("mid_frame_state", dbg_state, GET_B);
        check("mid_frame_a", alu_a, 8'h05);
        do_reset("rst_get_b");

        send_oper(8'h05, 8'h03, 4'd0, 1'b1);
        wait_done(60, "oper_05_03");
        send_noop(4'd2, 1'b1);
        wait_done(60, "noop_02");
        send_byte(8'h55);
        send_oper(8'hFF, 8'h02, 4'd2, 1'b1);
        wait_done(60, "junk_then_oper");

        // transmitter busy for 20 cycles while the low byte is pending; a CC byte is dropped
        @(posedge clk);
        #1;
        force_busy = 1'b1;
        send_oper(8'h3C, 8'h11, 4'd1, 1'b0);
        wait_state(SEND_LO, 30, "hold");
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            rx_d_vld  = (i == 5);
            rx_p_data = CMD_OPER;
            @(negedge clk);
            check("hold_no_tx_vld", tx_d_vld, 0);
            check("hold_ctrl_busy", ctrl_busy, 1);
        end
        @(posedge clk);
        #1;
        rx_d_vld   = 1'b0;
        force_busy = 1'b0;
        wait_done(80, "hold");
        send_noop(4'd0, 1'b1);
        wait_done(60, "after_hold");

        // reset while a TX byte is pending: nothing may be emitted afterwards
        @(posedge clk);
        #1;
        force_busy = 1'b1;
        send_oper(8'h21, 8'h43, 4'd3, 1'b0);
        wait_state(SEND_LO, 30, "rst_tx");
        repeat (3) @(negedge clk);
        do_reset("rst_send_lo");
        force_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_tx", tx_d_vld, 0);
        end

        // OUT_VALID outside WAIT_RES is ignored
        @(posedge clk);
        #1;
        ov_stray = 1'b1;
        @(posedge clk);
        #1;
        ov_stray = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stray_ov_state", dbg_state, IDLE);
            check("stray_ov_tx", tx_d_vld, 0);
        end

        // randomised frames, junk bytes and late results
        rand_dly = 1'b1;
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                send_oper(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'b1);
            end else if (r < 8) begin
                send_noop(4'($urandom_range(0, 15)), 1'b1);
            end else begin
                send_byte(8'($urandom_range(0, 8'hCB)));
                send_oper(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 1'b1);
            end
            wait_done(80, "random");
        end
        rand_dly = 1'b0;

`ifdef ALU_TIMEOUT_EN
        alu_silent = 1'b1;
        send_oper(8'h12, 8'h34, 4'd0, 1'b1);
        wait_done(80, "timeout");
        alu_silent = 1'b0;
        check("timeout_back_idle", dbg_state, IDLE);
`endif

        repeat (8) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("alu_q_drained", alu_exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
